// File: rtl/io_port_bank_if.sv
// Bus bundle between the CPU I/O decode plus external devices and the I/O bank.
// master: CPU stores/loads and external producers/consumers. slave: the bank.
interface io_port_bank_if #(
    parameter int WIDTH = 8
) ();
    // CPU write side (output channels)
    logic                 we;
    logic [1:0]           wa;
    logic [WIDTH-1:0]     wd;
    logic                 ovf;
    // CPU read side (input channels)
    logic                 re;
    logic [1:0]           ra;
    logic [WIDTH-1:0]     rd;
    logic [7:0]           rstat;
    // External consumers
    logic [4*WIDTH-1:0]   out_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    // External producers
    logic [4*WIDTH-1:0]   in_data;
    logic [3:0]           in_valid;
    logic [3:0]           in_ready;

    modport master (
        output we, wa, wd, re, ra, out_ready, in_data, in_valid,
        input  ovf, rd, rstat, out_data, out_valid, in_ready
    );

    modport slave (
        input  we, wa, wd, re, ra, out_ready, in_data, in_valid,
        output ovf, rd, rstat, out_data, out_valid, in_ready
    );
endinterface

// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: four output holding registers drained over
// valid/ready, four input FIFOs read by the CPU through a combinational port.
module io_port_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    io_port_bank_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_e;

    logic [4*WIDTH-1:0] w_out_data;
    logic [3:0]         w_out_valid;
    logic [3:0]         w_drop;
    logic [3:0]         w_nonempty;
    logic [3:0]         w_in_ready;
    logic [WIDTH-1:0]   w_head [4];
    logic               r_ovf;

    for (genvar g = 0; g < 4; g++) begin : g_out
        out_state_e       r_state;
        out_state_e       w_next;
        logic [WIDTH-1:0] r_data;
        logic             w_wr;
        logic             w_load;
        logic             w_valid;
        logic             w_drop_ch;

        assign w_wr = bus.we && (bus.wa == 2'(g));

        // Channel state register
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_state <= S_EMPTY;
            else       r_state <= w_next;
        end

        // Next state: a write fills, a handshake without a write drains
        // NOTE: defaults first in every always_comb so no path infers a latch.
        always_comb begin
            w_next = r_state;
            case (r_state)
                S_EMPTY: if (w_wr) w_next = S_FULL;
                S_FULL:  if (bus.out_ready[g] && !w_wr) w_next = S_EMPTY;
                default: w_next = S_EMPTY;
            endcase
        end

        // Outputs: a write into a FULL channel only lands if the consumer takes the old word
        always_comb begin
            w_valid   = 1'b0;
            w_load    = 1'b0;
            w_drop_ch = 1'b0;
            case (r_state)
                S_EMPTY: w_load = w_wr;
                S_FULL: begin
                    w_valid   = 1'b1;
                    w_load    = w_wr && bus.out_ready[g];
                    w_drop_ch = w_wr && !bus.out_ready[g];
                end
                default: ;
            endcase
        end

        // Holding register; unchanged while the consumer stalls
        always_ff @(posedge clk or posedge reset) begin
            if (reset)       r_data <= '0;
            else if (w_load) r_data <= bus.wd;
        end

        assign w_out_data[g*WIDTH +: WIDTH] = r_data;
        assign w_out_valid[g]               = w_valid;
        assign w_drop[g]                    = w_drop_ch;
    end

    for (genvar g = 0; g < 4; g++) begin : g_in
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_count;
        logic             w_push;
        logic             w_pop;

        // in_ready comes only from the count, so a same-cycle pop never frees a slot early
        assign w_in_ready[g] = (r_count < FULL_CNT);
        assign w_nonempty[g] = (r_count != '0);
        assign w_push        = bus.in_valid[g] && w_in_ready[g];
        assign w_pop         = bus.re && (bus.ra == 2'(g)) && w_nonempty[g];

        // FIFO storage
        // NOTE: storage is not reset; the count/pointer reset makes stale entries unreachable.
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wptr] <= bus.in_data[g*WIDTH +: WIDTH];
        end

        // Pointers wrap naturally (power-of-two depth); count tracks occupancy
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: ;
                endcase
            end
        end

        assign w_head[g] = r_mem[r_rptr];
    end

    // Overflow flag: one registered pulse per dropped CPU write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ovf <= 1'b0;
        else       r_ovf <= |w_drop;
    end

    assign bus.rd        = w_nonempty[bus.ra] ? w_head[bus.ra] : '0;
    assign bus.rstat     = {w_nonempty, ~w_out_valid};
    assign bus.ovf       = r_ovf;
    assign bus.out_data  = w_out_data;
    assign bus.out_valid = w_out_valid;
    assign bus.in_ready  = w_in_ready;
endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with scoreboard queues for both directions.
module tb_io_port_bank;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    logic [7:0] sb_out [4][$];
    logic [7:0] sb_in  [4][$];

    io_port_bank_if #(.WIDTH(8)) bus ();

    io_port_bank #(.WIDTH(8), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: compare scoreboard at the negedge, then step past the rising edge.
    task automatic cycle();
        logic [7:0] e;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid[c] && bus.out_ready[c]) begin
                check($sformatf("xfer%0d_expected", c), 32'(sb_out[c].size() != 0), 1);
                if (sb_out[c].size() != 0) begin
                    e = sb_out[c].pop_front();
                    check($sformatf("xfer%0d_data", c), 32'(bus.out_data[c*8 +: 8]), 32'(e));
                end
            end
        end
        if (bus.re) begin
            e = (sb_in[bus.ra].size() != 0) ? sb_in[bus.ra].pop_front() : 8'h00;
            check($sformatf("rd_pop_ch%0d", bus.ra), 32'(bus.rd), 32'(e));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass        = 0;
        n_total       = 0;
        reset         = 1'b1;
        bus.we        = 1'b0;
        bus.wa        = 2'd0;
        bus.wd        = 8'h00;
        bus.re        = 1'b0;
        bus.ra        = 2'd0;
        bus.out_ready = 4'h0;
        bus.in_data   = '0;
        bus.in_valid  = 4'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready",  32'(bus.in_ready), 32'hF);
        check("rst_rd",        32'(bus.rd), 0);
        check("rst_rstat",     32'(bus.rstat), 32'h0F);
        check("rst_ovf",       32'(bus.ovf), 0);
        reset = 1'b0;
        cycle();

        // Output channel 2: load, dropped write, drain
        bus.we = 1'b1; bus.wa = 2'd2; bus.wd = 8'hA5; sb_out[2].push_back(8'hA5);
        cycle();
        bus.wd = 8'h3C;
        check("ch2_valid",  32'(bus.out_valid[2]), 1);
        check("ch2_data",   32'(bus.out_data[23:16]), 32'hA5);
        check("ch2_rstat",  32'(bus.rstat[2]), 0);
        cycle();
        bus.we = 1'b0;
        check("ch2_ovf_hi",   32'(bus.ovf), 1);
        check("ch2_data_kept", 32'(bus.out_data[23:16]), 32'hA5);
        cycle();
        check("ch2_ovf_lo", 32'(bus.ovf), 0);
        bus.out_ready[2] = 1'b1;
        cycle();
        bus.out_ready[2] = 1'b0;
        check("ch2_drained", 32'(bus.out_valid[2]), 0);

        // Output channel 0: back-to-back streaming
        bus.out_ready[0] = 1'b1;
        bus.we = 1'b1; bus.wa = 2'd0;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] v;
            v = 8'(8'h11 * (k + 1));
            bus.wd = v;
            sb_out[0].push_back(v);
            cycle();
            check("ch0_valid", 32'(bus.out_valid[0]), 1);
            check("ch0_data",  32'(bus.out_data[7:0]), 32'(v));
            check("ch0_no_ovf", 32'(bus.ovf), 0);
        end
        bus.we = 1'b0;
        cycle();
        bus.out_ready[0] = 1'b0;
        check("ch0_empty", 32'(bus.out_valid[0]), 0);
        check("ch0_no_ovf_end", 32'(bus.ovf), 0);

        // Input FIFO 3: fill, drain
        bus.in_valid[3] = 1'b1; bus.in_data[31:24] = 8'h7E; sb_in[3].push_back(8'h7E);
        cycle();
        bus.in_data[31:24] = 8'h81; sb_in[3].push_back(8'h81);
        cycle();
        bus.in_valid[3] = 1'b0;
        check("in3_full",     32'(bus.in_ready[3]), 0);
        check("in3_nonempty", 32'(bus.rstat[7]), 1);
        bus.ra = 2'd3;
        #1;
        check("in3_head", 32'(bus.rd), 32'h7E);
        bus.re = 1'b1;
        cycle();
        check("in3_ready_back", 32'(bus.in_ready[3]), 1);
        check("in3_second",     32'(bus.rd), 32'h81);
        cycle();
        bus.re = 1'b0;
        check("in3_rd_zero",  32'(bus.rd), 0);
        check("in3_empty",    32'(bus.rstat[7]), 0);

        // Input FIFO 1: pop a full FIFO while a producer offers; no pass-through
        bus.ra = 2'd1;
        bus.in_valid[1] = 1'b1; bus.in_data[15:8] = 8'h10; sb_in[1].push_back(8'h10);
        cycle();
        bus.in_data[15:8] = 8'h20; sb_in[1].push_back(8'h20);
        cycle();
        bus.in_data[15:8] = 8'h5A;
        bus.re = 1'b1;
        check("in1_full_before", 32'(bus.in_ready[1]), 0);
        cycle();
        bus.re = 1'b0;
        check("in1_head_after_pop", 32'(bus.rd), 32'h20);
        check("in1_ready_after_pop", 32'(bus.in_ready[1]), 1);
        sb_in[1].push_back(8'h5A);
        cycle();
        bus.in_valid[1] = 1'b0;
        check("in1_full_again", 32'(bus.in_ready[1]), 0);
        check("in1_nonempty",   32'(bus.rstat[5]), 1);
        bus.re = 1'b1;
        cycle();
        cycle();
        bus.re = 1'b0;
        check("in1_rd_zero", 32'(bus.rd), 0);

        // Input FIFO 0: pop while empty, then push
        bus.ra = 2'd0;
        bus.re = 1'b1;
        cycle();
        bus.re = 1'b0;
        check("in0_still_empty", 32'(bus.rstat[4]), 0);
        check("in0_ready",       32'(bus.in_ready[0]), 1);
        bus.in_valid[0] = 1'b1; bus.in_data[7:0] = 8'hC3; sb_in[0].push_back(8'hC3);
        cycle();
        bus.in_valid[0] = 1'b0;
        check("in0_head", 32'(bus.rd), 32'hC3);
        bus.re = 1'b1;
        cycle();
        bus.re = 1'b0;

        // Reset mid-stream: FIFO 1 holding two entries, channel 1 holding a word
        bus.ra = 2'd1;
        bus.in_valid[1] = 1'b1; bus.in_data[15:8] = 8'h44; sb_in[1].push_back(8'h44);
        bus.we = 1'b1; bus.wa = 2'd1; bus.wd = 8'h99; sb_out[1].push_back(8'h99);
        cycle();
        bus.we = 1'b0;
        bus.in_data[15:8] = 8'h55; sb_in[1].push_back(8'h55);
        cycle();
        bus.in_valid[1] = 1'b0;
        check("mid_rstat_pre", 32'(bus.rstat), 32'h2D);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rstat",     32'(bus.rstat), 32'h0F);
        check("mid_out_valid", 32'(bus.out_valid), 0);
        check("mid_in_ready",  32'(bus.in_ready), 32'hF);
        check("mid_rd",        32'(bus.rd), 0);
        check("mid_out_data",  32'(bus.out_data), 0);
        for (int c = 0; c < 4; c++) begin
            sb_in[c].delete();
            sb_out[c].delete();
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        check("post_rst_rstat", 32'(bus.rstat), 32'h0F);

        begin
            int left;
            left = 0;
            for (int c = 0; c < 4; c++) left += sb_in[c].size() + sb_out[c].size();
            check("sb_drained", 32'(left), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
